mem_stage_unit: RTL and testbench
=================================

// Module: mem_stage_unit
// PURPOSE
//  Memory stage of the 5-stage Y86-64 pipeline; consumer end of the execute->memory pipeline register.
//  Takes the M_* fields, decodes the access, and runs a req/ack handshake to the data memory.
//  Produces registered m_* results for the writeback register.
//  Stalls the upstream pipeline while an access is outstanding.
// PARAMETERS
//  MEM_BYTES   65536  data memory size; any access with addr+8 > MEM_BYTES is SADR, no bus request
//  TIMEOUT     16     cycles in REQ without mem_ack before the access is declared SADR (>=2)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-high
//  M_valid    in   1   M_* fields hold a real instruction (0 = bubble)
//  M_stat     in   3   status from execute
//  M_icode    in   4   instruction code
//  M_Cnd      in   1   condition flag (passed through)
//  M_valE     in   64  ALU result / address
//  M_valA     in   64  store data / pop-ret address / call return address
//  M_dstE     in   4   E destination register (passed through)
//  M_dstM     in   4   M destination register (passed through)
//  W_exc      in   1   writeback stage holds an exception; suppresses memory writes
//  mem_req    out  1   bus request, registered
//  mem_we     out  1   1 = write, 0 = read; valid with mem_req
//  mem_addr   out  64  byte address; valid with mem_req
//  mem_wdata  out  64  write data; valid with mem_req
//  mem_ack    in   1   single-cycle completion from memory
//  mem_rdata  in   64  read data, valid with mem_ack
//  mem_err    in   1   bus error, valid with mem_ack
//  m_stall    out  1   freeze F/D/E/M registers (combinational)
//  m_valid    out  1   m_* holds a completed instruction this cycle
//  m_stat, m_icode, m_Cnd, m_valE, m_valM, m_dstE, m_dstM  out  3/4/1/64/64/4/4   registered results
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_req=mem_we=0; mem_addr=mem_wdata=0; m_valid=0; m_stat=SAOK(1).
//    Reset also clears every other m_* output and the timeout counter to 0.
//  Decode:
//    read  = MRMOVQ(5), POPQ(B), RET(9)
//    write = RMMOVQ(4), PUSHQ(A), CALL(8)
//    addr  = M_valE, except POPQ/RET use M_valA
//    wdata = M_valA
//  go = M_valid & (read|write) & M_stat==SAOK & ~(write & W_exc) & addr in range
//  FSM IDLE:
//    go -> REQ: mem_req<=1; mem_we/addr/wdata latched at the same edge.
//    M_valid & ~go -> m_* <= M_*, m_valid<=1 (1-cycle latency); m_valM=0.
//      Out-of-range read/write that is otherwise enabled: m_stat <= SADR(3).
//      Write blocked by W_exc or by M_stat!=SAOK: no request, m_stat <= M_stat.
//    ~M_valid -> m_valid<=0.
//  FSM REQ:
//    Hold mem_req and latched fields until mem_ack; cnt increments each cycle.
//    On mem_ack: m_valM <= mem_rdata (reads; 0 for writes); m_stat <= mem_err ? SADR : SAOK.
//      m_valid<=1; mem_req<=0; -> IDLE.
//    On cnt==TIMEOUT-1 without ack: m_stat<=SADR, m_valid<=1, mem_req<=0, -> IDLE.
//      A late ack after timeout is ignored.
//    m_valid=0 every cycle spent in REQ.
//  m_stall = (IDLE & go) | (REQ & ~mem_ack & ~timeout). Upstream holds M_* stable while m_stall=1.
//  Latency: non-memory = 1 clk; memory = cycles to ack + 1. Back-to-back accesses: no idle cycle needed.
//  mem_ack in IDLE is ignored. M_Cnd/dstE/dstM/valE/icode are captured at request time and re-emitted.
//  Reset mid-REQ drops mem_req immediately; the memory must tolerate abandoned requests.
// STRUCTURE
//  y86_pkg: icode constants (IHALT..IPOPQ), stat codes SAOK=1 SHLT=2 SADR=3 SINS=4, widths.
//  Sub-module mem_bus_ctrl: IDLE/REQ FSM, timeout counter, bus signal registers.
//  Top level: decode, range check, m_* registers.
// TESTING
//  1 OPQ (icode 6) valid, valE=0x2A -> next clk m_valid=1, m_valE=0x2A, m_valM=0, mem_req never set.
//  2 MRMOVQ valE=0x100, ack after 3 clk with rdata=0xDEAD -> m_stall=1 for 3 clk; then m_valM=0xDEAD, m_stat=1.
//  3 PUSHQ valE=0xFFF8 valA=0x55, W_exc=1 -> no mem_req; m_stat=1, m_valid=1 next clk.
//  4 RMMOVQ valE=0x1_0000 (out of range) -> no mem_req; m_stat=3 next clk.
//  5 POPQ valA=0x200, no ack -> mem_req for TIMEOUT clk; then m_stat=3; late ack ignored.
//  6 rst pulse while REQ -> mem_req=0, m_valid=0 same cycle; state IDLE; next MRMOVQ completes normally.

Source files
------------

// File: rtl/mem_stage_unit_pkg.sv
// mem_stage_unit_pkg: Y86-64 icode/stat constants, bus FSM state and access-decode helpers.
package mem_stage_unit_pkg;
  localparam int XLEN = 64;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 4'd4;
  typedef enum logic {BUS_IDLE, BUS_REQ} bus_state_e;
  function automatic logic is_read(input logic [3:0] ic);
    return ic == IMRMOVQ || ic == IPOPQ || ic == IRET;
  endfunction
  function automatic logic is_write(input logic [3:0] ic);
    return ic == IRMMOVQ || ic == IPUSHQ || ic == ICALL;
  endfunction
endpackage

// File: rtl/mem_stage_unit_if.sv
// mem_stage_unit_if: req/ack data-memory bus between the memory stage and data memory.
interface mem_stage_unit_if;
  import mem_stage_unit_pkg::*;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata, mem_err);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata, mem_err);
endinterface

// File: rtl/mem_stage_unit_bus_ctrl.sv
// mem_bus_ctrl: IDLE/REQ bus FSM with timeout; owns the registered bus request signals.
module mem_bus_ctrl
  import mem_stage_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  mem_stage_unit_if.master bus,
  output logic            busy_o,
  output logic            fin_o,
  output logic            fin_adr_o,
  output logic            stall_o
);
  localparam int CW = $clog2(TIMEOUT);
  bus_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic last;
  assign last      = cnt_q == CW'(TIMEOUT - 1);
  assign busy_o    = state_q == BUS_REQ;
  assign fin_o     = busy_o & (bus.mem_ack | last);
  // ack wins over a same-cycle timeout
  assign fin_adr_o = ~bus.mem_ack | bus.mem_err;
  assign stall_o   = busy_o ? ~fin_o : go_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= BUS_IDLE;
      cnt_q         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (busy_o) begin
      cnt_q <= fin_o ? '0 : cnt_q + CW'(1);
      if (fin_o) begin
        state_q     <= BUS_IDLE;
        bus.mem_req <= 1'b0;
      end
    end else if (go_i) begin
      state_q       <= BUS_REQ;
      cnt_q         <= '0;
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= we_i;
      bus.mem_addr  <= addr_i;
      bus.mem_wdata <= wdata_i;
    end
endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: Y86-64 memory stage; decodes M_* access, drives the data bus, registers m_* results.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter longint unsigned MEM_BYTES = 65536,
  parameter int              TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            M_valid_i,
  input  logic [2:0]      M_stat_i,
  input  logic [3:0]      M_icode_i,
  input  logic            M_Cnd_i,
  input  logic [XLEN-1:0] M_valE_i,
  input  logic [XLEN-1:0] M_valA_i,
  input  logic [3:0]      M_dstE_i,
  input  logic [3:0]      M_dstM_i,
  input  logic            W_exc_i,
  mem_stage_unit_if.master bus,
  output logic            m_stall_o,
  output logic            m_valid_o,
  output logic [2:0]      m_stat_o,
  output logic [3:0]      m_icode_o,
  output logic            m_Cnd_o,
  output logic [XLEN-1:0] m_valE_o,
  output logic [XLEN-1:0] m_valM_o,
  output logic [3:0]      m_dstE_o,
  output logic [3:0]      m_dstM_o
);
  logic rd, wr, en, in_rng, go, busy, fin, fin_adr;
  logic [XLEN-1:0] addr;
  assign rd     = is_read(M_icode_i);
  assign wr     = is_write(M_icode_i);
  assign addr   = (M_icode_i == IPOPQ || M_icode_i == IRET) ? M_valA_i : M_valE_i;
  // 65-bit sum so addresses near 2^64 cannot wrap into range
  assign in_rng = {1'b0, addr} + 65'd8 <= 65'(MEM_BYTES);
  assign en     = M_valid_i & (rd | wr) & (M_stat_i == SAOK) & ~(wr & W_exc_i);
  assign go     = en & in_rng;
  mem_bus_ctrl #(.TIMEOUT(TIMEOUT)) u_bus (
    .clk      (clk),
    .rst      (rst),
    .go_i     (go),
    .we_i     (wr),
    .addr_i   (addr),
    .wdata_i  (M_valA_i),
    .bus      (bus),
    .busy_o   (busy),
    .fin_o    (fin),
    .fin_adr_o(fin_adr),
    .stall_o  (m_stall_o)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid_o <= 1'b0;
      m_stat_o  <= SAOK;
      m_icode_o <= '0;
      m_Cnd_o   <= 1'b0;
      m_valE_o  <= '0;
      m_valM_o  <= '0;
      m_dstE_o  <= '0;
      m_dstM_o  <= '0;
    end else if (busy) begin
      m_valid_o <= fin;
      if (fin) begin
        m_stat_o <= fin_adr ? SADR : SAOK;
        m_valM_o <= (bus.mem_ack & ~bus.mem_we) ? bus.mem_rdata : '0;
      end
    end else if (M_valid_i) begin
      m_valid_o <= ~go;
      m_stat_o  <= (en & ~in_rng) ? SADR : M_stat_i;
      m_icode_o <= M_icode_i;
      m_Cnd_o   <= M_Cnd_i;
      m_valE_o  <= M_valE_i;
      m_valM_o  <= '0;
      m_dstE_o  <= M_dstE_i;
      m_dstM_o  <= M_dstM_i;
    end else
      m_valid_o <= 1'b0;
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed vectors with a result scoreboard and a small data-memory responder.
module tb_mem_stage_unit;
  logic clk = 1'b0;
  logic rst;
  logic M_valid_i, M_Cnd_i, W_exc_i;
  logic [2:0] M_stat_i;
  logic [3:0] M_icode_i, M_dstE_i, M_dstM_i;
  logic [63:0] M_valE_i, M_valA_i;
  logic m_stall_o, m_valid_o, m_Cnd_o;
  logic [2:0] m_stat_o;
  logic [3:0] m_icode_o, m_dstE_o, m_dstM_o;
  logic [63:0] m_valE_o, m_valM_o;
  mem_stage_unit_if bus ();
  mem_stage_unit dut (
    .clk(clk), .rst(rst), .M_valid_i(M_valid_i), .M_stat_i(M_stat_i), .M_icode_i(M_icode_i),
    .M_Cnd_i(M_Cnd_i), .M_valE_i(M_valE_i), .M_valA_i(M_valA_i), .M_dstE_i(M_dstE_i),
    .M_dstM_i(M_dstM_i), .W_exc_i(W_exc_i), .bus(bus), .m_stall_o(m_stall_o),
    .m_valid_o(m_valid_o), .m_stat_o(m_stat_o), .m_icode_o(m_icode_o), .m_Cnd_o(m_Cnd_o),
    .m_valE_o(m_valE_o), .m_valM_o(m_valM_o), .m_dstE_o(m_dstE_o), .m_dstM_o(m_dstM_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } exp_t;
  exp_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int errors = 0;
  int ack_dly = 0;
  int wait_cnt = 0;
  int req_cnt = 0;
  logic force_ack = 1'b0;
  logic err_val = 1'b0;
  logic [63:0] rd_val = '0;
  logic [63:0] last_addr = '0, last_wdata = '0;
  logic last_we = 1'b0;
  assign bus.mem_rdata = rd_val;
  assign bus.mem_err   = err_val;
  always @(posedge clk) begin
    #1;
    bus.mem_ack = force_ack;
    if (rst || bus.mem_req !== 1'b1) wait_cnt = 0;
    else begin
      last_addr  = bus.mem_addr;
      last_wdata = bus.mem_wdata;
      last_we    = bus.mem_we;
      wait_cnt++;
      if (ack_dly != 0 && wait_cnt == ack_dly) begin
        bus.mem_ack = 1'b1;
        wait_cnt = 0;
      end
    end
  end
  always @(negedge clk) if (bus.mem_req === 1'b1) req_cnt++;
  always @(negedge clk)
    if (!rst && m_valid_o !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_result: m_valid=%b with no expected result", m_valid_o);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if ({m_stat_o, m_icode_o, m_Cnd_o, m_valE_o, m_valM_o, m_dstE_o, m_dstM_o} !==
            {e.stat, e.icode, e.cnd, e.vale, e.valm, e.dste, e.dstm}) begin
          errors++;
          $display("FAIL %s: got stat=%0d icode=%h Cnd=%b valE=%h valM=%h dstE=%h dstM=%h; want stat=%0d icode=%h Cnd=%b valE=%h valM=%h dstE=%h dstM=%h",
                   n, m_stat_o, m_icode_o, m_Cnd_o, m_valE_o, m_valM_o, m_dstE_o, m_dstM_o,
                   e.stat, e.icode, e.cnd, e.vale, e.valm, e.dste, e.dstm);
        end
      end
    end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic expect_res(input string n, input logic [2:0] st, input logic [3:0] ic, input logic c,
                            input logic [63:0] ve, input logic [63:0] vm, input logic [3:0] de,
                            input logic [3:0] dm);
    exp_t e;
    e.stat = st; e.icode = ic; e.cnd = c; e.vale = ve; e.valm = vm; e.dste = de; e.dstm = dm;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  // called at posedge+1; holds M_* until the stage accepts, returns at posedge+1 after acceptance
  task automatic issue(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                       input logic [2:0] st, input logic wexc, input logic [3:0] de,
                       input logic [3:0] dm, input logic c, output int stalls);
    logic s;
    M_valid_i = 1'b1; M_icode_i = ic; M_valE_i = ve; M_valA_i = va; M_stat_i = st;
    W_exc_i = wexc; M_dstE_i = de; M_dstM_i = dm; M_Cnd_i = c;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = m_stall_o;
      if (s) stalls++;
      @(posedge clk);
      #1;
      if (!s) begin
        M_valid_i = 1'b0;
        W_exc_i = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout: m_stall=1 after 40 cycles, want release");
    M_valid_i = 1'b0;
    W_exc_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int st, r0;
    rst = 1'b1; M_valid_i = 0; M_stat_i = 3'd1; M_icode_i = 0; M_Cnd_i = 0;
    M_valE_i = 0; M_valA_i = 0; M_dstE_i = 4'hF; M_dstM_i = 4'hF; W_exc_i = 0;
    #12;
    chk("rst_mem_req", 64'(bus.mem_req), 0);
    chk("rst_mem_we", 64'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_m_valid", 64'(m_valid_o), 0);
    chk("rst_m_stat", 64'(m_stat_o), 1);
    chk("rst_m_valE", m_valE_o, 0);
    chk("rst_m_valM", m_valM_o, 0);
    chk("rst_m_stall", 64'(m_stall_o), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    r0 = req_cnt;
    expect_res("opq", 3'd1, 4'h6, 1'b1, 64'h2A, 0, 4'h3, 4'hF);
    issue(4'h6, 64'h2A, 64'h0, 3'd1, 1'b0, 4'h3, 4'hF, 1'b1, st);
    chk("opq_stall", 64'(st), 0);
    chk("opq_no_req", 64'(req_cnt - r0), 0);
    ack_dly = 3; rd_val = 64'hDEAD;
    expect_res("mrmovq", 3'd1, 4'h5, 1'b0, 64'h100, 64'hDEAD, 4'hF, 4'h2);
    issue(4'h5, 64'h100, 64'h0, 3'd1, 1'b0, 4'hF, 4'h2, 1'b0, st);
    chk("mrmovq_stall", 64'(st), 3);
    chk("mrmovq_addr", last_addr, 64'h100);
    chk("mrmovq_we", 64'(last_we), 0);
    ack_dly = 1;
    expect_res("rmmovq_wr", 3'd1, 4'h4, 1'b0, 64'hFFF8, 0, 4'hF, 4'hF);
    issue(4'h4, 64'hFFF8, 64'h1234, 3'd1, 1'b0, 4'hF, 4'hF, 1'b0, st);
    chk("rmmovq_wr_stall", 64'(st), 1);
    chk("rmmovq_wr_addr", last_addr, 64'hFFF8);
    chk("rmmovq_wr_wdata", last_wdata, 64'h1234);
    chk("rmmovq_wr_we", 64'(last_we), 1);
    r0 = req_cnt;
    expect_res("pushq_wexc", 3'd1, 4'hA, 1'b0, 64'hFFF8, 0, 4'h4, 4'hF);
    issue(4'hA, 64'hFFF8, 64'h55, 3'd1, 1'b1, 4'h4, 4'hF, 1'b0, st);
    chk("pushq_wexc_stall", 64'(st), 0);
    expect_res("rmmovq_oor", 3'd3, 4'h4, 1'b0, 64'h10000, 0, 4'hF, 4'hF);
    issue(4'h4, 64'h10000, 64'h9, 3'd1, 1'b0, 4'hF, 4'hF, 1'b0, st);
    chk("rmmovq_oor_stall", 64'(st), 0);
    expect_res("mrmovq_fff9", 3'd3, 4'h5, 1'b0, 64'hFFF9, 0, 4'hF, 4'h1);
    issue(4'h5, 64'hFFF9, 64'h0, 3'd1, 1'b0, 4'hF, 4'h1, 1'b0, st);
    expect_res("popq_sins", 3'd4, 4'hB, 1'b0, 64'h8, 0, 4'h4, 4'h5);
    issue(4'hB, 64'h8, 64'h200, 3'd4, 1'b0, 4'h4, 4'h5, 1'b0, st);
    chk("no_req_blocked", 64'(req_cnt - r0), 0);
    ack_dly = 1; rd_val = 64'h1111;
    expect_res("b2b_a", 3'd1, 4'h5, 1'b1, 64'h400, 64'h1111, 4'hF, 4'h6);
    expect_res("b2b_b", 3'd1, 4'h5, 1'b0, 64'h408, 64'h1111, 4'hF, 4'h7);
    issue(4'h5, 64'h400, 64'h0, 3'd1, 1'b0, 4'hF, 4'h6, 1'b1, st);
    issue(4'h5, 64'h408, 64'h0, 3'd1, 1'b0, 4'hF, 4'h7, 1'b0, st);
    chk("b2b_addr", last_addr, 64'h408);
    ack_dly = 2; rd_val = 64'h77; err_val = 1'b1;
    expect_res("mem_err", 3'd3, 4'h5, 1'b0, 64'h300, 64'h77, 4'hF, 4'h3);
    issue(4'h5, 64'h300, 64'h0, 3'd1, 1'b0, 4'hF, 4'h3, 1'b0, st);
    chk("mem_err_stall", 64'(st), 2);
    err_val = 1'b0;
    ack_dly = 0;
    r0 = req_cnt;
    expect_res("popq_timeout", 3'd3, 4'hB, 1'b0, 64'h108, 0, 4'h4, 4'h4);
    issue(4'hB, 64'h108, 64'h200, 3'd1, 1'b0, 4'h4, 4'h4, 1'b0, st);
    chk("timeout_stall", 64'(st), 16);
    chk("timeout_req_cycles", 64'(req_cnt - r0), 16);
    chk("timeout_addr", last_addr, 64'h200);
    force_ack = 1'b1;
    @(posedge clk); #3;
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", 64'(m_valid_o), 0);
    chk("late_ack_stall", 64'(m_stall_o), 0);
    @(negedge clk);
    chk("late_ack_valid2", 64'(m_valid_o), 0);
    @(posedge clk); #1;
    M_valid_i = 1'b1; M_icode_i = 4'h5; M_valE_i = 64'h500; M_stat_i = 3'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 64'(bus.mem_req), 1);
    M_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreq_rst_req", 64'(bus.mem_req), 0);
    chk("midreq_rst_valid", 64'(m_valid_o), 0);
    chk("midreq_rst_stall", 64'(m_stall_o), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ack_dly = 2; rd_val = 64'hBEEF;
    expect_res("after_rst", 3'd1, 4'h5, 1'b0, 64'h600, 64'hBEEF, 4'hF, 4'h8);
    issue(4'h5, 64'h600, 64'h0, 3'd1, 1'b0, 4'hF, 4'h8, 1'b0, st);
    chk("after_rst_stall", 64'(st), 2);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
